// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one Memory between N_REQ clients. The read
// and write ports are arbitrated independently, and each supports a bounded lock.

module mem_port_arb #(
  parameter  int N_REQ    = 4,
  parameter  int MAX_LOCK = 16,
  localparam int IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CW       = (MAX_LOCK > 0) ? $clog2(MAX_LOCK + 1) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] lock,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    gnt_idx
);
  // With a single requester, locking is meaningless, so the lock path is disabled.
  localparam bit LOCK_EN = (N_REQ > 1);

  logic [IW-1:0]    ptr, own, win;
  logic             own_vld, found;
  logic [CW-1:0]    cnt;
  logic [N_REQ-1:0] elig;

  always_comb begin
    int j;
    j     = 0;
    elig  = req;
    found = 1'b0;
    win   = '0;
    // At the limit, the owner sits out one normal round. Otherwise only the owner may win.
    if (own_vld) begin
      if (cnt == CW'(MAX_LOCK)) elig[own] = 1'b0;
      else                      elig = req & (N_REQ'(1) << own);
    end
    for (int o = 0; o < N_REQ; o++) begin
      j = (int'(ptr) + o) % N_REQ;
      if (!found && elig[IW'(j)]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
  end

  assign gnt     = (found ? (N_REQ'(1) << win) : '0) & {N_REQ{rst_n}};
  assign gnt_idx = win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      own     <= '0;
      own_vld <= 1'b0;
      cnt     <= '0;
    end else if (found) begin
      ptr     <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
      own     <= win;
      own_vld <= LOCK_EN && lock[win];
      cnt     <= (own_vld && own == win && lock[win]) ? cnt + 1'b1 : '0;
    end else begin
      // No grant means either the bus is idle or the owner has left, so the lock is dropped.
      own_vld <= 1'b0;
      cnt     <= '0;
    end
  end
endmodule

module mem_port_arbiter #(
  parameter  int N_REQ    = 4,
  parameter  int DEPTH    = 10,
  parameter  int WIDTH    = 16,
  parameter  int MAX_LOCK = 16,
  localparam int IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       rd_req,
  input  logic [N_REQ-1:0]       rd_lock,
  input  logic [N_REQ*DEPTH-1:0] rd_addr,
  output logic [N_REQ-1:0]       rd_gnt,
  output logic [N_REQ-1:0]       rd_valid,
  output logic [WIDTH-1:0]       rd_data,
  input  logic [N_REQ-1:0]       wr_req,
  input  logic [N_REQ-1:0]       wr_lock,
  input  logic [N_REQ*DEPTH-1:0] wr_addr,
  input  logic [N_REQ*WIDTH-1:0] wr_data,
  output logic [N_REQ-1:0]       wr_gnt,
  output logic [DEPTH-1:0]       mem_read_addr,
  output logic [DEPTH-1:0]       mem_write_addr,
  output logic [WIDTH-1:0]       mem_data_in,
  output logic                   mem_write_enable,
  input  logic [WIDTH-1:0]       mem_data_out
);
  // Port 0 is the read port and port 1 is the write port.
  logic [1:0][N_REQ-1:0] req_v, lock_v, gnt_v;
  logic [1:0][IW-1:0]    idx_v;

  assign req_v  = {wr_req, rd_req};
  assign lock_v = {wr_lock, rd_lock};

  for (genvar g = 0; g < 2; g++) begin : g_port
    mem_port_arb #(.N_REQ(N_REQ), .MAX_LOCK(MAX_LOCK)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_v[g]),
      .lock    (lock_v[g]),
      .gnt     (gnt_v[g]),
      .gnt_idx (idx_v[g])
    );
  end

  assign rd_gnt           = gnt_v[0];
  assign wr_gnt           = gnt_v[1];
  assign mem_write_enable = |wr_gnt;
  assign mem_read_addr    = (|rd_gnt) ? rd_addr[idx_v[0]*DEPTH +: DEPTH] : '0;
  assign mem_write_addr   = (|wr_gnt) ? wr_addr[idx_v[1]*DEPTH +: DEPTH] : '0;
  assign mem_data_in      = (|wr_gnt) ? wr_data[idx_v[1]*WIDTH +: WIDTH] : '0;
  assign rd_data          = mem_data_out;

  // Memory registers the read address, so the data returns one cycle after the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_valid <= '0;
    else        rd_valid <= rd_gnt;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. A behavioural Memory sits behind the DUT, and a
// spec-level model checks every output on every cycle.

module tb_mem_port_arbiter;
  localparam int N = 4, D = 10, W = 16, ML = 4;

  logic clk = 1'b0, rst_n;
  logic [N-1:0]   rd_req, rd_lock, wr_req, wr_lock, rd_gnt, rd_valid, wr_gnt;
  logic [N*D-1:0] rd_addr, wr_addr;
  logic [N*W-1:0] wr_data;
  logic [W-1:0]   rd_data, mem_data_in, mem_data_out;
  logic [D-1:0]   mem_read_addr, mem_write_addr;
  logic           mem_write_enable;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.N_REQ(N), .DEPTH(D), .WIDTH(W), .MAX_LOCK(ML)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_lock(rd_lock), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_lock(wr_lock), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_gnt(wr_gnt), .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
    .mem_data_in(mem_data_in), .mem_write_enable(mem_write_enable),
    .mem_data_out(mem_data_out)
  );

  // Memory stand-in: a registered read address, which gives write-first behaviour.
  logic [W-1:0] bmem [2**D];
  logic [D-1:0] ra_q;
  always @(posedge clk) begin
    if (mem_write_enable) bmem[mem_write_addr] <= mem_data_in;
    ra_q <= mem_read_addr;
  end
  assign mem_data_out = bmem[ra_q];

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state per port: rotation start, the current burst owner, and the burst length.
  int m_ptr[2], m_own[2], m_burst[2];
  bit m_ov[2];
  logic [N-1:0] m_rv;
  int m_raddr;
  logic [W-1:0] mmem [2**D];

  function automatic int pick(int p, logic [N-1:0] req);
    int ex = -1;
    if (m_ov[p]) begin
      if (m_burst[p] > ML) ex = m_own[p];
      else return req[m_own[p]] ? m_own[p] : -1;
    end
    for (int o = 0; o < N; o++) begin
      int j = (m_ptr[p] + o) % N;
      if (req[j] && j != ex) return j;
    end
    return -1;
  endfunction

  task automatic step(int p, int w, logic [N-1:0] lock);
    if (w < 0) m_ov[p] = 0;
    else begin
      m_ptr[p] = (w + 1) % N;
      if (lock[w]) begin
        if (m_ov[p] && m_own[p] == w) m_burst[p]++;
        else begin m_own[p] = w; m_burst[p] = 1; end
        m_ov[p] = 1;
      end else m_ov[p] = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    int rw, ww;
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin m_ptr[p] = 0; m_ov[p] = 0; m_burst[p] = 0; m_own[p] = 0; end
      m_rv = '0;
    end else begin
      rw = pick(0, rd_req);
      ww = pick(1, wr_req);
      if (ww >= 0) mmem[wr_addr[ww*D +: D]] = wr_data[ww*W +: W];
      m_rv = (rw >= 0) ? N'(1) << rw : '0;
      if (rw >= 0) m_raddr = int'(rd_addr[rw*D +: D]);
      step(0, rw, rd_lock);
      step(1, ww, wr_lock);
    end
  end

  always @(negedge clk) begin
    int rw, ww;
    rw = rst_n ? pick(0, rd_req) : -1;
    ww = rst_n ? pick(1, wr_req) : -1;
    check("rd_gnt", 32'(rd_gnt), (rw >= 0) ? 32'(1) << rw : 32'(0));
    check("wr_gnt", 32'(wr_gnt), (ww >= 0) ? 32'(1) << ww : 32'(0));
    check("mem_read_addr", 32'(mem_read_addr), (rw >= 0) ? 32'(rd_addr[rw*D +: D]) : 32'(0));
    check("mem_write_enable", 32'(mem_write_enable), 32'(ww >= 0));
    check("mem_write_addr", 32'(mem_write_addr), (ww >= 0) ? 32'(wr_addr[ww*D +: D]) : 32'(0));
    check("mem_data_in", 32'(mem_data_in), (ww >= 0) ? 32'(wr_data[ww*W +: W]) : 32'(0));
    check("rd_valid", 32'(rd_valid), 32'(m_rv));
    if (m_rv != '0) check("rd_data", 32'(rd_data), 32'(mmem[m_raddr]));
  end

  task automatic tick; @(posedge clk); #1; endtask
  task automatic clr;
    rd_req = '0; rd_lock = '0; rd_addr = '0;
    wr_req = '0; wr_lock = '0; wr_addr = '0; wr_data = '0;
  endtask
  task automatic do_reset; clr(); rst_n = 1'b0; tick(); rst_n = 1'b1; endtask

  initial begin
    int seq[7] = '{1, 1, 1, 1, 1, 3, 1};
    clr();
    rst_n = 1'b0; rd_req = '1; wr_req = '1;
    tick(); #3;
    check("reset rd_gnt", 32'(rd_gnt), 0);
    check("reset wr_gnt", 32'(wr_gnt), 0);
    check("reset we", 32'(mem_write_enable), 0);
    check("reset rd_valid", 32'(rd_valid), 0);
    tick(); clr(); rst_n = 1'b1;

    // Write 0x00AB to address 5, then read it back.
    wr_req[2] = 1'b1; wr_addr[2*D +: D] = 10'd5; wr_data[2*W +: W] = 16'h00AB;
    #3 check("t1 wr_gnt", 32'(wr_gnt), 32'b0100);
    check("t1 waddr", 32'(mem_write_addr), 5);
    tick(); clr(); rd_req[1] = 1'b1; rd_addr[1*D +: D] = 10'd5;
    #3 check("t1 rd_gnt", 32'(rd_gnt), 32'b0010);
    tick(); clr();
    #3 check("t1 rd_valid", 32'(rd_valid), 32'b0010);
    check("t1 rd_data", 32'(rd_data), 32'h00AB);

    // Fairness
    tick(); do_reset(); rd_req = '1;
    for (int i = 0; i < 8; i++) begin
      #3 check("fair gnt", 32'(rd_gnt), 32'(1) << (i % 4));
      if (i > 0) check("fair valid", 32'(rd_valid), 32'(1) << ((i - 1) % 4));
      tick();
    end
    rd_req = '0;
    #3 check("fair last valid", 32'(rd_valid), 32'b1000);

    // Lock limit
    tick(); do_reset(); rd_req[1] = 1'b1; rd_lock[1] = 1'b1; rd_req[3] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #3 check("lock seq", 32'(rd_gnt), 32'(1) << seq[i]);
      tick();
      if (i == 5) rd_req[3] = 1'b0;
    end
    clr();

    // Parallel ports with a same-address collision
    tick(); do_reset();
    wr_req[0] = 1'b1; wr_addr[0 +: D] = 10'd7; wr_data[0 +: W] = 16'h1234;
    rd_req[3] = 1'b1; rd_addr[3*D +: D] = 10'd7;
    #3 check("col wr_gnt", 32'(wr_gnt), 32'b0001);
    check("col rd_gnt", 32'(rd_gnt), 32'b1000);
    tick(); clr();
    #3 check("col valid", 32'(rd_valid), 32'b1000);
    check("col data", 32'(rd_data), 32'h1234);

    // Owner drops its request while still holding lock
    tick(); do_reset(); rd_req[2] = 1'b1; rd_lock[2] = 1'b1;
    #3 check("drop gnt0", 32'(rd_gnt), 32'b0100);
    tick(); rd_req[2] = 1'b0; rd_req[0] = 1'b1;
    #3 check("drop bubble", 32'(rd_gnt), 0);
    tick(); rd_lock[2] = 1'b0;
    #3 check("drop next", 32'(rd_gnt), 32'b0001);
    tick(); clr();

    // Reset asserted one cycle after a read grant
    rd_req[1] = 1'b1; rd_addr[1*D +: D] = 10'd5;
    #3 check("mid rd_gnt", 32'(rd_gnt), 32'b0010);
    tick(); rst_n = 1'b0; clr();
    #3 check("mid rd_valid", 32'(rd_valid), 0);
    tick(); rst_n = 1'b1; rd_req = '1;
    #3 check("mid first gnt", 32'(rd_gnt), 32'b0001);
    tick(); clr();

    // Mixed traffic on both ports, checked against the model only
    for (int i = 0; i < 16; i++) begin
      rd_req  = 4'(i * 5 + 3);
      rd_lock = (i % 3 == 0) ? 4'b0100 : 4'b0000;
      wr_req  = ~4'(i);
      wr_lock = 4'b0010;
      for (int k = 0; k < N; k++) begin
        rd_addr[k*D +: D] = ((i + k) % 2 == 1) ? 10'd5 : 10'd7;
        wr_addr[k*D +: D] = ((i + k) % 2 == 0) ? 10'd5 : 10'd7;
        wr_data[k*W +: W] = 16'(i * 16 + k + 16'h0100);
      end
      tick();
    end
    clr();
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
